// File: rtl/lpif_rxfifo_x2_half_credit.sv
// -----------------------------------------------------------------------------
// lpif_rxfifo_x2_half_credit
//
// Receive-side buffer for the x2 asymmetric half-rate LPIF logic link.
// Packed words arriving from the AIB receive path go into a DEPTH-entry FIFO.
// The head word is presented first-word-fall-through from a registered output
// stage. One link-layer credit is returned per word consumed, and DEPTH
// credits are returned as a burst when the link comes up.
//
// Ports:
//   clk_wr                  logic-link clock
//   rst_wr                  asynchronous active-high reset
//   rx_online               link up (level, synchronous to clk_wr)
//   rxfifo_push_data/_vld   word and strobe from the AIB receive path
//   rxfifo_downstream_data  head-of-FIFO word (registered)
//   rxfifo_downstream_vld   head word valid (registered)
//   rxfifo_downstream_rdy   consumer accepts the head word
//   rx_credit_return        single-cycle pulse, one credit returned
//   fifo_level              occupancy 0..DEPTH (registered)
//   fifo_full / fifo_empty  occupancy flags (registered)
//   fifo_overflow           sticky, a push was dropped; cleared by rst_wr only
//
// Optional build macro LPIF_RXFIFO_HWM_EN adds:
//   fifo_hwm_clr            pulse: load fifo_hwm with the current fifo_level
//   fifo_hwm                highest fifo_level seen since reset / link up
// -----------------------------------------------------------------------------
module lpif_rxfifo_x2_half_credit #(
  parameter  int DATA_W = 150,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  input  logic              rx_online,
  input  logic [DATA_W-1:0] rxfifo_push_data,
  input  logic              rxfifo_push_vld,
  output logic [DATA_W-1:0] rxfifo_downstream_data,
  output logic              rxfifo_downstream_vld,
  input  logic              rxfifo_downstream_rdy,
  output logic              rx_credit_return,
  output logic [AW:0]       fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_overflow
`ifdef LPIF_RXFIFO_HWM_EN
  ,
  input  logic              fifo_hwm_clr,
  output logic [AW:0]       fifo_hwm
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic {ST_OFFLINE, ST_ONLINE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, level_d;
  logic [AW:0]       credit_pend, credit_d;
  logic [DATA_W-1:0] head_d;
  logic              go_online, flush, online_act;
  logic              pop, push_acc, push_drop, credit_issue;

  // ---------------------------------------------------------------------------
  // Link state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_wr) state_q <= ST_OFFLINE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_OFFLINE: if (rx_online)  state_d = ST_ONLINE;
      ST_ONLINE:  if (!rx_online) state_d = ST_OFFLINE;
      default:                    state_d = ST_OFFLINE;
    endcase
  end

  assign go_online  = (state_q == ST_OFFLINE) &&  rx_online;
  assign flush      = (state_q == ST_ONLINE)  && !rx_online;
  assign online_act = (state_q == ST_ONLINE)  &&  rx_online;

  // A push at full is still taken when the head leaves on the same edge.
  assign pop          = online_act && rxfifo_downstream_vld && rxfifo_downstream_rdy;
  assign push_acc     = online_act && rxfifo_push_vld && (!fifo_full || pop);
  assign push_drop    = online_act && rxfifo_push_vld && !push_acc;
  assign credit_issue = online_act && (credit_pend != '0);

  // ---------------------------------------------------------------------------
  // Next pointers, level and head word
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr + ONE_C;
      if (pop)      rd_ptr_d = rd_ptr + ONE_C;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    // When the next head is the slot being written on this edge, the word is
    // not in storage yet: bypass it straight into the output register.
    if (push_acc && (rd_ptr_d == wr_ptr)) head_d = rxfifo_push_data;
    else                                  head_d = mem[rd_ptr_d[AW-1:0]];
  end

  always_comb begin
    credit_d = credit_pend;
    if (go_online)       credit_d = DEPTH_C;
    else if (flush)      credit_d = '0;
    else if (online_act) begin
      if (pop && !credit_issue)      credit_d = credit_pend + ONE_C;
      else if (!pop && credit_issue) credit_d = credit_pend - ONE_C;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; validity is tracked by the pointers, and
  // leaving it unreset lets it map onto plain RAM or flop arrays.
  always_ff @(posedge clk_wr) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= rxfifo_push_data;
  end

  // ---------------------------------------------------------------------------
  // Registered pointers, outputs and credit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      credit_pend            <= '0;
      rxfifo_downstream_data <= '0;
      rxfifo_downstream_vld  <= 1'b0;
      rx_credit_return       <= 1'b0;
      fifo_level             <= '0;
      fifo_full              <= 1'b0;
      fifo_empty             <= 1'b0;
      fifo_overflow          <= 1'b0;
    end else begin
      wr_ptr                <= wr_ptr_d;
      rd_ptr                <= rd_ptr_d;
      credit_pend           <= credit_d;
      rxfifo_downstream_vld <= (level_d != '0);
      // Data only moves with a valid head, so it is stable under backpressure.
      if (level_d != '0) rxfifo_downstream_data <= head_d;
      rx_credit_return      <= credit_issue;
      fifo_level            <= level_d;
      fifo_full             <= (level_d == DEPTH_C);
      fifo_empty            <= (level_d == '0);
      fifo_overflow         <= fifo_overflow | push_drop;
    end
  end

  // Credits outstanding can never exceed the buffer size.
  credit_no_overrun: assert property (@(posedge clk_wr) disable iff (rst_wr)
    !(pop && !credit_issue && (credit_pend == DEPTH_C)));

`ifdef LPIF_RXFIFO_HWM_EN
  // Tracks the registered level, so it follows one cycle after a level change.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr)                   fifo_hwm <= '0;
    else if (go_online)           fifo_hwm <= '0;
    else if (fifo_hwm_clr)        fifo_hwm <= fifo_level;
    else if (fifo_level > fifo_hwm) fifo_hwm <= fifo_level;
  end
`endif

endmodule

// File: tb/tb_lpif_rxfifo_x2_half_credit.sv
// -----------------------------------------------------------------------------
// tb_lpif_rxfifo_x2_half_credit
//
// Directed self-checking bench for lpif_rxfifo_x2_half_credit (default build,
// DATA_W=150, DEPTH=8). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, i.e. they reflect the edge just
// taken. Credit pulses are counted once per cycle at the sample point.
// -----------------------------------------------------------------------------
module tb_lpif_rxfifo_x2_half_credit;

  localparam int DATA_W = 150;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);

  logic              clk_wr = 1'b0;
  logic              rst_wr = 1'b0;
  logic              rx_online = 1'b0;
  logic [DATA_W-1:0] rxfifo_push_data = '0;
  logic              rxfifo_push_vld = 1'b0;
  logic [DATA_W-1:0] rxfifo_downstream_data;
  logic              rxfifo_downstream_vld;
  logic              rxfifo_downstream_rdy = 1'b0;
  logic              rx_credit_return;
  logic [AW:0]       fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;

  int checks   = 0;
  int failures = 0;
  int cred_cnt = 0;

  lpif_rxfifo_x2_half_credit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_wr                 (clk_wr),
    .rst_wr                 (rst_wr),
    .rx_online              (rx_online),
    .rxfifo_push_data       (rxfifo_push_data),
    .rxfifo_push_vld        (rxfifo_push_vld),
    .rxfifo_downstream_data (rxfifo_downstream_data),
    .rxfifo_downstream_vld  (rxfifo_downstream_vld),
    .rxfifo_downstream_rdy  (rxfifo_downstream_rdy),
    .rx_credit_return       (rx_credit_return),
    .fifo_level             (fifo_level),
    .fifo_full              (fifo_full),
    .fifo_empty             (fifo_empty),
    .fifo_overflow          (fifo_overflow)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk_wr);
    #1;
    if (rx_credit_return === 1'b1) cred_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},  rxfifo_downstream_vld, 0);
    check({tag, "_data"}, rxfifo_downstream_data, 0);
    check({tag, "_lvl"},  fifo_level, 0);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_empt"}, fifo_empty, 0);
    check({tag, "_ovf"},  fifo_overflow, 0);
    check({tag, "_cred"}, rx_credit_return, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and initial credit burst ----------------
    #1 rst_wr = 1'b1;
    #1 check_all_zero("rst");
    #10 rst_wr = 1'b0;
    step();                               // OFFLINE edge
    check("off_empty", fifo_empty, 1);
    check("off_cred", rx_credit_return, 0);
    rx_online = 1'b1;
    step();                               // goes ONLINE, credits loaded
    check("on_edge_cred", rx_credit_return, 0);
    cred_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("burst_pulse", rx_credit_return, 1);
    end
    check("burst_cnt", cred_cnt, 8);
    step();
    check("burst_end", rx_credit_return, 0);
    check("burst_empty", fifo_empty, 1);

    // ---------------- three words under backpressure ----------------
    rxfifo_push_vld = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rxfifo_push_data = DATA_W'(i);
      step();
      check("p3_first_data", rxfifo_downstream_data, 1);
    end
    rxfifo_push_vld = 1'b0;
    check("p3_level", fifo_level, 3);
    check("p3_vld", rxfifo_downstream_vld, 1);
    step();
    check("p3_hold", rxfifo_downstream_data, 1);
    check("p3_empty", fifo_empty, 0);
    rxfifo_downstream_rdy = 1'b1;
    cred_cnt = 0;
    step();
    check("p3_d2", rxfifo_downstream_data, 2);
    check("p3_l2", fifo_level, 2);
    step();
    check("p3_d3", rxfifo_downstream_data, 3);
    check("p3_l1", fifo_level, 1);
    step();
    check("p3_vld0", rxfifo_downstream_vld, 0);
    check("p3_l0", fifo_level, 0);
    check("p3_empty1", fifo_empty, 1);
    step();
    step();
    check("p3_credits", cred_cnt, 3);
    rxfifo_downstream_rdy = 1'b0;

    // ---------------- fill, overflow, push-at-full with pop ----------------
    rxfifo_push_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rxfifo_push_data = DATA_W'(8'h10 + i);
      step();
    end
    check("fill_full", fifo_full, 1);
    check("fill_level", fifo_level, 8);
    check("fill_ovf0", fifo_overflow, 0);
    rxfifo_push_data = DATA_W'(8'hEE);
    step();
    check("ovf_set", fifo_overflow, 1);
    check("ovf_level", fifo_level, 8);
    check("ovf_head", rxfifo_downstream_data, 8'h10);
    rxfifo_push_data = DATA_W'(8'h18);
    rxfifo_downstream_rdy = 1'b1;
    cred_cnt = 0;
    step();
    check("fullpp_level", fifo_level, 8);
    check("fullpp_full", fifo_full, 1);
    check("fullpp_head", rxfifo_downstream_data, 8'h11);
    rxfifo_push_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rxfifo_downstream_data, DATA_W'(8'h11 + i));
      check("drain_vld", rxfifo_downstream_vld, 1);
      step();
    end
    check("drain_level", fifo_level, 0);
    check("drain_empty", fifo_empty, 1);
    step();
    step();
    check("drain_credits", cred_cnt, 9);
    check("ovf_sticky", fifo_overflow, 1);

    // ---------------- streaming push+pop across pointer wraps ----------------
    cred_cnt = 0;
    rxfifo_push_vld = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rxfifo_push_data = DATA_W'(16'h100 + k);
      step();
      check("stream_data", rxfifo_downstream_data, DATA_W'(16'h100 + k));
      check("stream_level", fifo_level, 1);
    end
    rxfifo_push_vld = 1'b0;
    step();
    check("stream_l0", fifo_level, 0);
    check("stream_vld0", rxfifo_downstream_vld, 0);
    step();
    step();
    check("stream_credits", cred_cnt, 20);
    rxfifo_downstream_rdy = 1'b0;

    // ---------------- link drop flushes, relink gives a fresh burst ----------
    rxfifo_push_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rxfifo_push_data = DATA_W'(16'h200 + i);
      step();
    end
    check("pre_drop_level", fifo_level, 5);
    check("pre_drop_head", rxfifo_downstream_data, 16'h200);
    rxfifo_push_vld = 1'b0;
    rx_online = 1'b0;
    cred_cnt = 0;
    step();
    check("drop_vld", rxfifo_downstream_vld, 0);
    check("drop_level", fifo_level, 0);
    check("drop_empty", fifo_empty, 1);
    rxfifo_push_vld = 1'b1;
    rxfifo_push_data = DATA_W'(16'hBAD);
    step();
    check("off_push_level", fifo_level, 0);
    check("off_push_vld", rxfifo_downstream_vld, 0);
    rxfifo_push_vld = 1'b0;
    step();
    check("drop_no_cred", cred_cnt, 0);
    rx_online = 1'b1;
    step();
    cred_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    check("reburst_cnt", cred_cnt, 8);
    step();
    check("reburst_end", rx_credit_return, 0);
    check("reburst_ovf", fifo_overflow, 1);

    // ---------------- asynchronous reset mid-stream ----------------
    rxfifo_push_vld = 1'b1;
    rxfifo_push_data = DATA_W'(16'h300);
    step();
    rxfifo_push_data = DATA_W'(16'h301);
    step();
    rxfifo_push_vld = 1'b0;
    check("pre_rst_level", fifo_level, 2);
    check("pre_rst_data", rxfifo_downstream_data, 16'h300);
    #2 rst_wr = 1'b1;
    #1 check_all_zero("arst");
    #2 rst_wr = 1'b0;
    step();                               // goes ONLINE again
    check("post_rst_cred0", rx_credit_return, 0);
    cred_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    check("post_rst_burst", cred_cnt, 8);
    step();
    check("post_rst_end", rx_credit_return, 0);
    check("post_rst_empty", fifo_empty, 1);
    check("post_rst_ovf", fifo_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpif_rxfifo_x2_half_credit.md
Name: lpif_rxfifo_x2_half_credit

Overview:
Receive-side buffer for the x2 asymmetric half-rate LPIF logic link. It accepts 150-bit packed words from the AIB receive path and stores them in a DEPTH-entry FIFO. Words are presented to the downstream unpacker as rxfifo_downstream_data with a valid/ready handshake. The block also returns one link-layer credit to the far-side transmitter per word consumed, plus an initial credit burst when the link comes up.

Parameters:
- DATA_W, 150, packed word width. Must match the unpacker input width.
- DEPTH, 8, FIFO entries. Power of 2, range 2..64.
- AW, $clog2(DEPTH), pointer index width (derived, not overridable).

Ports:
- clk_wr  in  1  logic-link clock.
- rst_wr  in  1  asynchronous active-high reset.
- rx_online  in  1  link up. Level, synchronous to clk_wr.
- rxfifo_push_data  in  DATA_W  word from the AIB receive path.
- rxfifo_push_vld  in  1  push strobe, one word per cycle.
- rxfifo_downstream_data  out  DATA_W  head-of-FIFO word.
- rxfifo_downstream_vld  out  1  head word valid.
- rxfifo_downstream_rdy  in  1  consumer accepts the head word.
- rx_credit_return  out  1  single-cycle pulse = one credit returned.
- fifo_level  out  AW+1  current occupancy, 0..DEPTH.
- fifo_full  out  1  fifo_level == DEPTH.
- fifo_empty  out  1  fifo_level == 0.
- fifo_overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (rst_wr high, async):
  - All outputs 0; FSM = OFFLINE; pointers 0; credit pending counter 0.
  - rxfifo_downstream_data resets to all zeros.
- FSM has two states, OFFLINE and ONLINE.
  - OFFLINE -> ONLINE on the first clk_wr edge with rx_online=1. On that edge, credit_pend loads DEPTH.
  - ONLINE -> OFFLINE on any edge with rx_online=0. On that edge:
    - flush: pointers, level and credit_pend clear to 0;
    - rxfifo_downstream_vld drops low the next cycle;
    - fifo_overflow is NOT cleared (only rst_wr clears it).
  - In OFFLINE, pushes are ignored and not counted as overflow.
- Push:
  - Accepted in ONLINE when rxfifo_push_vld=1 and either (level<DEPTH) or (level==DEPTH and a pop occurs the same cycle).
  - Otherwise a push in ONLINE is dropped, fifo_overflow sets, and FIFO contents are unchanged.
- Pop: occurs when rxfifo_downstream_vld && rxfifo_downstream_rdy.
- Output register:
  - First-word-fall-through with registered outputs.
  - Latency: a push at edge N into an empty FIFO gives vld=1 with that data after edge N.
  - Data and vld are held stable while vld=1 and rdy=0.
  - Back-to-back pops sustain one word per cycle.
- Level:
  - Push only: +1. Pop only: -1. Both: unchanged.
  - fifo_full, fifo_empty and fifo_level are registered, consistent with vld (fifo_empty == !vld).
- Pointers: AW+1 bits with wrap bit. Wrap-around at DEPTH is transparent; no bubble at the wrap.
- Credits:
  - credit_pend counter, AW+1 bits, max DEPTH.
  - rx_credit_return = (credit_pend != 0) in ONLINE, registered.
  - Each pulse decrements credit_pend. Each pop increments it. Pop and pulse in the same cycle leave it unchanged.
  - credit_pend never exceeds DEPTH; an increment at DEPTH is an assertion error.
  - Initial burst: exactly DEPTH pulses on consecutive cycles after going ONLINE, absent pops.
- rx_online dropping mid-burst: the remaining credits are discarded and no further pulses occur.

Optional Feature:
- Macro: LPIF_RXFIFO_HWM_EN.
- Defined:
  - Adds output fifo_hwm [AW:0], the highest fifo_level seen since reset or since the last OFFLINE->ONLINE transition, updated on the cycle after the level changes.
  - Adds input fifo_hwm_clr (1 bit); a pulse sets fifo_hwm to the current fifo_level.
  - Reset value 0.
- Undefined: no such ports and no logic.

Test Plan:
- Reset then rx_online=1 with no traffic -> exactly 8 rx_credit_return pulses on cycles 1..8 after ONLINE, then 0; fifo_empty=1; all outputs 0 during reset.
- Push 0x1, 0x2, 0x3 with rdy=0 -> level=3, vld=1, data=0x1 held; then rdy=1 for 3 cycles -> data 0x1, 0x2, 0x3 on consecutive cycles, 3 credit pulses, level=0.
- Fill 8 words with rdy=0 -> fifo_full=1. A 9th push with rdy=0 is dropped and fifo_overflow=1 (sticky). A push with rdy=1 at full is accepted and level stays 8.
- Continuous push+pop of 20 words with rdy=1 -> in-order data across two pointer wraps, level steady at 1, 20 credit pulses.
- Push 5 words then drop rx_online -> next cycle vld=0, level=0, no credit pulses. Re-assert rx_online -> a fresh burst of 8 pulses; fifo_overflow keeps its prior value.
- rst_wr asserted mid-stream (asynchronously, between edges) -> all outputs 0 immediately; after release with rx_online=1, the initial credit burst repeats.
